// File: rtl/snax_reqrsp_to_hwpe.sv
`default_nettype none
// ============================================================================
// Module   : snax_reqrsp_to_hwpe
// Purpose  : Bridges a SNAX/Snitch TCDM reqrsp initiator (q_valid/q_ready,
//            p_valid) onto an HWPE TCDM master port (req/gnt/r_valid).
//            Requests are buffered in a FIFO and issued in order. Read
//            responses return in order through a one-cycle response register.
// Ports    : clk_i, rst_ni (async, active-low)
//            tcdm_req_q_*_i / tcdm_req_q_valid_i : reqrsp request channel
//            tcdm_rsp_q_ready_o, tcdm_rsp_p_*_o  : reqrsp response channel
//            hwpe_tcdm_*                         : HWPE TCDM master (32b addr/data)
//            err_o                               : sticky protocol error flag
// Revision : 1.0 - initial release
// ============================================================================
module snax_reqrsp_to_hwpe #(
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned UserWidth      = 1,
  parameter int unsigned ReqDepth       = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // reqrsp request
  input  logic [AddrWidth-1:0]   tcdm_req_q_addr_i,
  input  logic                   tcdm_req_q_write_i,
  input  logic [3:0]             tcdm_req_q_amo_i,
  input  logic [DataWidth-1:0]   tcdm_req_q_data_i,
  input  logic [DataWidth/8-1:0] tcdm_req_q_strb_i,
  input  logic [UserWidth-1:0]   tcdm_req_q_user_i,
  input  logic                   tcdm_req_q_valid_i,
  // reqrsp response
  output logic                   tcdm_rsp_q_ready_o,
  output logic                   tcdm_rsp_p_valid_o,
  output logic [DataWidth-1:0]   tcdm_rsp_p_data_o,
  // HWPE TCDM master
  output logic                   hwpe_tcdm_req_o,
  input  logic                   hwpe_tcdm_gnt_i,
  output logic [31:0]            hwpe_tcdm_add_o,
  output logic                   hwpe_tcdm_wen_o,
  output logic [3:0]             hwpe_tcdm_be_o,
  output logic [31:0]            hwpe_tcdm_data_o,
  input  logic [31:0]            hwpe_tcdm_r_data_i,
  input  logic                   hwpe_tcdm_r_valid_i,
  // status
  output logic                   err_o
);

  localparam int unsigned PtrWidth   = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
  localparam int unsigned FillWidth  = $clog2(ReqDepth + 1);
  localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 1);
  localparam int unsigned EntryWidth = 32 + 1 + 32 + 4;
  localparam logic [3:0]  AmoNone    = 4'h0;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Issue = 2'd1,
    Stall = 2'd2
  } state_e;

  // FIFO entry layout: {addr[31:0], write, data[31:0], strb[3:0]}
  logic [EntryWidth-1:0] r_mem [ReqDepth];
  logic [PtrWidth-1:0]   r_wptr, r_rptr;
  logic [FillWidth-1:0]  r_fill;
  logic [CntWidth-1:0]   r_count;
  state_e                r_state;
  logic                  r_p_valid;
  logic [31:0]           r_p_data;
  logic                  r_err;

  logic                  w_full, w_push, w_req, w_pop, w_rd_grant, w_rsp, w_bad_rsp;
  logic [EntryWidth-1:0] w_head, w_push_entry;
  logic                  w_head_write, w_next_head_write;
  logic [PtrWidth-1:0]   w_wptr_inc, w_rptr_inc, w_rptr_next;
  logic [FillWidth-1:0]  w_fill_next;
  logic [CntWidth-1:0]   w_count_next;
  state_e                w_state_next;
  logic                  w_unused;

  // Upper address/data/strobe bits and user are intentionally dropped.
  assign w_unused = ^{tcdm_req_q_addr_i, tcdm_req_q_data_i, tcdm_req_q_strb_i, tcdm_req_q_user_i};

  assign w_full             = (r_fill == FillWidth'(ReqDepth));
  assign tcdm_rsp_q_ready_o = rst_ni & ~w_full;
  assign w_push             = tcdm_req_q_valid_i & tcdm_rsp_q_ready_o;
  assign w_push_entry       = {tcdm_req_q_addr_i[31:0], tcdm_req_q_write_i,
                               tcdm_req_q_data_i[31:0], tcdm_req_q_strb_i[3:0]};

  assign w_head       = r_mem[r_rptr];
  assign w_head_write = w_head[36];
  assign w_req        = (r_state == Issue);
  assign w_pop        = w_req & hwpe_tcdm_gnt_i;
  assign w_rd_grant   = w_pop & ~w_head_write;
  assign w_rsp        = hwpe_tcdm_r_valid_i & (r_count != '0);
  assign w_bad_rsp    = hwpe_tcdm_r_valid_i & (r_count == '0);

  assign w_wptr_inc   = (r_wptr == PtrWidth'(ReqDepth - 1)) ? '0 : r_wptr + PtrWidth'(1);
  assign w_rptr_inc   = (r_rptr == PtrWidth'(ReqDepth - 1)) ? '0 : r_rptr + PtrWidth'(1);
  assign w_rptr_next  = w_pop ? w_rptr_inc : r_rptr;
  assign w_fill_next  = r_fill + FillWidth'(w_push) - FillWidth'(w_pop);
  assign w_count_next = r_count + CntWidth'(w_rd_grant) - CntWidth'(w_rsp);

  // Type of the entry that will sit at the head next cycle. When the next
  // read pointer lands on the slot being written this cycle, the head is the
  // incoming request (the slot is otherwise empty, since a full FIFO never pushes).
  assign w_next_head_write = (w_push && (w_rptr_next == r_wptr)) ? tcdm_req_q_write_i
                                                                 : r_mem[w_rptr_next][36];

  // Next state is decided from next-cycle FIFO/count values, so req is only
  // raised for a head that may legally issue; once raised it cannot be
  // withdrawn because count never grows without a grant.
  always_comb begin
    w_state_next = Issue;
    if (w_fill_next == '0) begin
      w_state_next = Idle;
    end else if (!w_next_head_write && (w_count_next == CntWidth'(MaxOutstanding))) begin
      w_state_next = Stall;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= Idle;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_fill    <= '0;
      r_count   <= '0;
      r_p_valid <= 1'b0;
      r_p_data  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rptr    <= w_rptr_next;
      r_fill    <= w_fill_next;
      r_count   <= w_count_next;
      r_p_valid <= w_rsp;
      if (w_push) r_wptr <= w_wptr_inc;
      if (w_rsp) r_p_data <= hwpe_tcdm_r_data_i;
      if (w_bad_rsp || (w_push && (tcdm_req_q_amo_i != AmoNone))) r_err <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked by r_fill.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_push_entry;
  end

  assign hwpe_tcdm_req_o  = w_req;
  assign hwpe_tcdm_add_o  = w_req ? w_head[68:37] : '0;
  assign hwpe_tcdm_wen_o  = w_req ? ~w_head_write : 1'b0;
  assign hwpe_tcdm_data_o = w_req ? w_head[35:4]  : '0;
  assign hwpe_tcdm_be_o   = w_req ? w_head[3:0]   : '0;

  assign tcdm_rsp_p_valid_o = r_p_valid;
  assign err_o              = r_err;

  generate
    if (DataWidth > 32) begin : g_pdata_wide
      assign tcdm_rsp_p_data_o = {{(DataWidth - 32){1'b0}}, r_p_data};
    end else begin : g_pdata_narrow
      assign tcdm_rsp_p_data_o = r_p_data;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_snax_reqrsp_to_hwpe.sv
`default_nettype none
// ============================================================================
// Module   : tb_snax_reqrsp_to_hwpe
// Purpose  : Self-checking bench for snax_reqrsp_to_hwpe. A queue-based
//            reference model is compared against the DUT every cycle, and
//            directed scenarios pin hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snax_reqrsp_to_hwpe;

  localparam int DW    = 64;
  localparam int AW    = 48;
  localparam int DEPTH = 4;
  localparam int MAXO  = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [AW-1:0] q_addr = '0;
  logic          q_write = 1'b0;
  logic [3:0]    q_amo = 4'h0;
  logic [DW-1:0] q_data = '0;
  logic [DW/8-1:0] q_strb = '0;
  logic [0:0]    q_user = '0;
  logic          q_valid = 1'b0;
  logic          gnt = 1'b0;
  logic [31:0]   r_data = '0;
  logic          r_valid = 1'b0;

  logic          q_ready, p_valid, req, wen, err;
  logic [DW-1:0] p_data;
  logic [31:0]   add, wdata;
  logic [3:0]    be;

  always #5 clk = ~clk;

  snax_reqrsp_to_hwpe #(
    .DataWidth(DW), .AddrWidth(AW), .UserWidth(1), .ReqDepth(DEPTH), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .tcdm_req_q_addr_i(q_addr), .tcdm_req_q_write_i(q_write), .tcdm_req_q_amo_i(q_amo),
    .tcdm_req_q_data_i(q_data), .tcdm_req_q_strb_i(q_strb), .tcdm_req_q_user_i(q_user),
    .tcdm_req_q_valid_i(q_valid),
    .tcdm_rsp_q_ready_o(q_ready), .tcdm_rsp_p_valid_o(p_valid), .tcdm_rsp_p_data_o(p_data),
    .hwpe_tcdm_req_o(req), .hwpe_tcdm_gnt_i(gnt), .hwpe_tcdm_add_o(add),
    .hwpe_tcdm_wen_o(wen), .hwpe_tcdm_be_o(be), .hwpe_tcdm_data_o(wdata),
    .hwpe_tcdm_r_data_i(r_data), .hwpe_tcdm_r_valid_i(r_valid),
    .err_o(err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_grants = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  be;
  } mreq_t;

  mreq_t       mq[$];
  int          m_outs = 0;
  bit          m_pv   = 0;
  logic [63:0] m_pd   = '0;
  bit          m_err  = 0;

  always @(negedge clk) begin
    if (!rst_ni) begin
      chk("rst_q_ready", q_ready, 0);
      chk("rst_req", req, 0);
      chk("rst_p_valid", p_valid, 0);
      chk("rst_p_data", p_data, 0);
      chk("rst_err", err, 0);
      chk("rst_add", {wen, be, add}, 0);
      chk("rst_wdata", wdata, 0);
      mq.delete();
      m_outs = 0;
      m_pv   = 0;
      m_err  = 0;
    end else begin
      bit m_ready, m_req, m_pop, m_push, m_rsp;
      m_ready = (mq.size() < DEPTH);
      // A request is presented whenever the head is a write or a read may still be outstanding.
      m_req = (mq.size() > 0) && !(!mq[0].wr && m_outs == MAXO);
      chk("q_ready", q_ready, m_ready);
      chk("req", req, m_req);
      chk("p_valid", p_valid, m_pv);
      chk("err", err, m_err);
      if (m_pv) chk("p_data", p_data, m_pd);
      if (m_req) begin
        chk("add", add, mq[0].addr);
        chk("wen", wen, !mq[0].wr);
        chk("be", be, mq[0].be);
        chk("wdata", wdata, mq[0].data);
      end
      // advance the model to the state after the coming rising edge
      m_pop  = m_req && gnt;
      m_push = q_valid && m_ready;
      m_rsp  = r_valid && (m_outs > 0);
      if (r_valid && m_outs == 0) m_err = 1;
      if (m_push && q_amo != 4'h0) m_err = 1;
      m_pv = m_rsp;
      if (m_rsp) m_pd = {32'h0, r_data};
      if (m_pop) begin
        n_grants++;
        if (!mq[0].wr) m_outs++;
        void'(mq.pop_front());
      end
      if (m_rsp) m_outs--;
      if (m_push) mq.push_back('{addr: q_addr[31:0], wr: q_write, data: q_data[31:0], be: q_strb[3:0]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                       input logic [DW/8-1:0] s);
    q_addr  = a;
    q_write = w;
    q_data  = d;
    q_strb  = s;
    q_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    repeat (3) step();
    chk("reset_q_ready", q_ready, 0);
    chk("reset_req", req, 0);
    chk("reset_err", err, 0);
    rst_ni = 1'b1;
    step();
    chk("post_reset_q_ready", q_ready, 1);

    // 1. single write, granted in its first req cycle
    g0 = n_grants;
    offer(48'hABCD_0000_0100, 1'b1, 64'hCAFE_F00D_DEAD_BEEF, 8'h0F);
    gnt = 1'b1;
    step();
    q_valid = 1'b0;
    chk("t1_req", req, 1);
    chk("t1_add", add, 32'h100);
    chk("t1_wen", wen, 0);
    chk("t1_be", be, 4'hF);
    chk("t1_data", wdata, 32'hDEADBEEF);
    step();
    gnt = 1'b0;
    repeat (3) step();
    chk("t1_grants", n_grants - g0, 1);
    chk("t1_req_idle", req, 0);

    // 2. read with response one cycle after grant
    offer(48'h40, 1'b0, '0, 8'hFF);
    gnt = 1'b1;
    step();
    q_valid = 1'b0;
    chk("t2_req", req, 1);
    chk("t2_wen", wen, 1);
    chk("t2_add", add, 32'h40);
    step();
    gnt = 1'b0;
    r_valid = 1'b1;
    r_data  = 32'h12345678;
    step();
    r_valid = 1'b0;
    chk("t2_p_valid", p_valid, 1);
    chk("t2_p_data", p_data, 64'h0000_0000_1234_5678);
    step();
    chk("t2_p_valid_once", p_valid, 0);

    // 3. five reads, gnt high, responses withheld
    g0 = n_grants;
    gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(48'h200 + 48'(4 * i), 1'b0, '0, 8'hFF);
      step();
    end
    q_valid = 1'b0;
    repeat (3) step();
    chk("t3_grants", n_grants - g0, 4);
    chk("t3_stall_req", req, 0);
    r_valid = 1'b1;
    r_data  = 32'h0000_00A0;
    step();
    r_valid = 1'b0;
    chk("t3_resume_req", req, 1);
    chk("t3_resume_add", add, 32'h210);
    step();
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_valid = 1'b1;
      r_data  = 32'hB0 + 32'(i);
      step();
    end
    r_valid = 1'b0;
    repeat (2) step();
    chk("t3_all_grants", n_grants - g0, 5);

    // 4. gnt low, five requests offered
    g0 = n_grants;
    for (int i = 0; i < 4; i++) begin
      offer(48'h300 + 48'(4 * i), 1'b1, 64'h1111_0000 + 64'(i), 8'h0F);
      chk("t4_q_ready_open", q_ready, 1);
      step();
    end
    offer(48'h310, 1'b1, 64'h2222_0000, 8'h03);
    chk("t4_q_ready_full", q_ready, 0);
    repeat (3) step();
    chk("t4_req_held", req, 1);
    chk("t4_head_stable", add, 32'h300);
    chk("t4_still_full", q_ready, 0);
    gnt = 1'b1;
    for (int k = 0; k < 10 && !q_ready; k++) step();
    chk("t4_q_ready_reopen", q_ready, 1);
    step();
    q_valid = 1'b0;
    repeat (6) step();
    gnt = 1'b0;
    chk("t4_grants", n_grants - g0, 5);

    // 5. r_valid with nothing outstanding
    step();
    chk("t5_err_before", err, 0);
    r_valid = 1'b1;
    r_data  = 32'h55;
    step();
    r_valid = 1'b0;
    chk("t5_err", err, 1);
    chk("t5_p_valid", p_valid, 0);
    repeat (3) step();
    chk("t5_err_sticky", err, 1);

    // 6. reset with two reads outstanding and two queued
    gnt = 1'b1;
    offer(48'h400, 1'b0, '0, 8'hFF);
    step();
    offer(48'h404, 1'b0, '0, 8'hFF);
    step();
    offer(48'h408, 1'b0, '0, 8'hFF);
    step();
    gnt = 1'b0;
    offer(48'h40C, 1'b0, '0, 8'hFF);
    step();
    q_valid = 1'b0;
    chk("t6_req_pending", req, 1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_req", req, 0);
    chk("t6_rst_p_valid", p_valid, 0);
    chk("t6_rst_q_ready", q_ready, 0);
    repeat (2) step();
    rst_ni = 1'b1;
    step();
    chk("t6_q_ready", q_ready, 1);
    chk("t6_req", req, 0);
    chk("t6_err_cleared", err, 0);

    // 7. AMO request runs as a plain write but flags an error
    offer(48'h500, 1'b1, 64'h0BAD_F00D, 8'h0F);
    q_amo = 4'h2;
    gnt = 1'b1;
    step();
    q_valid = 1'b0;
    q_amo = 4'h0;
    chk("t7_err", err, 1);
    chk("t7_req", req, 1);
    chk("t7_wen", wen, 0);
    chk("t7_add", add, 32'h500);
    step();
    gnt = 1'b0;

    // 6b. late r_valid after reset (count cleared) raises err
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    chk("t6b_err_clear", err, 0);
    r_valid = 1'b1;
    r_data  = 32'h77;
    step();
    r_valid = 1'b0;
    chk("t6b_late_err", err, 1);
    chk("t6b_p_valid", p_valid, 0);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
